// File: rtl/genetico_pkg.sv
// Shared types and width helpers for the genetic-algorithm blocks.
package genetico_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} fe_state_t;

  // Fitness width able to hold every possible mismatch (out bits x 2**in vectors).
  function automatic int fit_width(input int in, input int out);
    return $clog2(out * (2 ** in) + 1);
  endfunction

endpackage

// File: rtl/fitness_evaluator_if.sv
// GA / circuit-array side signals of the fitness evaluator.
// FITNESS_EARLY_ABORT_EN adds the abort threshold input and aborted flag.
interface fitness_evaluator_if #(
  parameter int IN  = 2,
  parameter int OUT = 1
);
  import genetico_pkg::*;

  localparam int NVEC  = 2 ** IN;
  localparam int FIT_W = fit_width(IN, OUT);

  logic                      start;
  logic [NVEC-1:0][OUT-1:0]  target;
  logic [IN-1:0]             cir_inp;
  logic [OUT-1:0]            cir_out;
  logic                      chrom_hold;
  logic                      busy;
  logic                      done;
  logic [FIT_W-1:0]          fitness;
  logic                      perfect;
`ifdef FITNESS_EARLY_ABORT_EN
  logic [FIT_W-1:0]          abort_thr;
  logic                      aborted;

  modport master (
    output start, target, cir_out, abort_thr,
    input  cir_inp, chrom_hold, busy, done, fitness, perfect, aborted
  );
  modport slave (
    input  start, target, cir_out, abort_thr,
    output cir_inp, chrom_hold, busy, done, fitness, perfect, aborted
  );
`else
  modport master (
    output start, target, cir_out,
    input  cir_inp, chrom_hold, busy, done, fitness, perfect
  );
  modport slave (
    input  start, target, cir_out,
    output cir_inp, chrom_hold, busy, done, fitness, perfect
  );
`endif

endinterface

// File: rtl/fitness_evaluator_popcount_n.sv
// Combinational count of set bits in an N-bit word.
module popcount_n #(
  parameter int N = 1
) (
  input  logic [N-1:0] bits,
  output logic [N-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + N'(bits[i]);
    end
  end

endmodule

// File: rtl/fitness_evaluator.sv
// Sweeps every input vector through the evolvable circuit and accumulates the
// Hamming distance to the target truth table. Optional: FITNESS_EARLY_ABORT_EN.
module fitness_evaluator
  import genetico_pkg::*;
#(
  parameter int IN     = 2,
  parameter int OUT    = 1,
  parameter int SETTLE = 1
) (
  input logic                clk,
  input logic                rst_n,
  fitness_evaluator_if.slave bus
);

  localparam int            NVEC       = 2 ** IN;
  localparam int            FIT_W      = fit_width(IN, OUT);
  localparam logic [IN-1:0] LAST_VEC   = IN'(NVEC - 1);
  localparam logic [3:0]    SETTLE_CNT = 4'(SETTLE);

  fe_state_t        state;
  logic [IN-1:0]    vec;
  logic [IN-1:0]    inp_r;
  logic [3:0]       cnt;
  logic [FIT_W-1:0] acc;
  logic [FIT_W-1:0] acc_next;
  logic [FIT_W-1:0] fit_r;
  logic             busy_r;
  logic             hold_r;
  logic             done_r;
  logic             perfect_r;
  logic [OUT-1:0]   mism;
  logic [OUT-1:0]   ones;
  logic             stop;

  assign mism = bus.cir_out ^ bus.target[vec];

  popcount_n #(.N(OUT)) u_popcount (
    .bits  (mism),
    .count (ones)
  );

  assign acc_next = acc + FIT_W'(ones);

`ifdef FITNESS_EARLY_ABORT_EN
  logic [FIT_W-1:0] thr_r;
  logic             aborted_r;

  assign stop        = (acc_next > thr_r);
  assign bus.aborted = aborted_r;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      inp_r     <= '0;
      cnt       <= '0;
      acc       <= '0;
      fit_r     <= '0;
      busy_r    <= 1'b0;
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
      perfect_r <= 1'b0;
`ifdef FITNESS_EARLY_ABORT_EN
      thr_r     <= '0;
      aborted_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            inp_r     <= '0;
            vec       <= '0;
            cnt       <= SETTLE_CNT;
            acc       <= '0;
            fit_r     <= '0;
            perfect_r <= 1'b0;
            busy_r    <= 1'b1;
            hold_r    <= 1'b1;
`ifdef FITNESS_EARLY_ABORT_EN
            thr_r     <= bus.abort_thr;
            aborted_r <= 1'b0;
`endif
            state     <= EVAL;
          end
        end
        EVAL: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (vec == LAST_VEC || stop) begin
            // Final (or aborting) sample: publish the result and release the GA.
            fit_r     <= acc_next;
            perfect_r <= (acc_next == '0) && !stop;
            busy_r    <= 1'b0;
            hold_r    <= 1'b0;
            done_r    <= 1'b1;
`ifdef FITNESS_EARLY_ABORT_EN
            aborted_r <= stop;
`endif
            state     <= DONE;
          end else begin
            acc   <= acc_next;
            vec   <= vec + 1'b1;
            inp_r <= vec + 1'b1;
            cnt   <= SETTLE_CNT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cir_inp    = inp_r;
  assign bus.chrom_hold = hold_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.fitness    = fit_r;
  assign bus.perfect    = perfect_r;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Bench for fitness_evaluator: two instances (1-bit and 2-bit outputs) driven by
// truth-table circuit models and checked against a mismatch-count reference.
module tb_fitness_evaluator;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  fitness_evaluator_if #(.IN(2), .OUT(1)) ifa ();
  fitness_evaluator_if #(.IN(2), .OUT(2)) ifb ();

  logic [3:0]      tt_a;
  logic [3:0][1:0] tt_b;

  assign ifa.cir_out = tt_a[ifa.cir_inp];
  assign ifb.cir_out = tt_b[ifb.cir_inp];

  fitness_evaluator #(.IN(2), .OUT(1), .SETTLE(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  fitness_evaluator #(.IN(2), .OUT(2), .SETTLE(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: number of truth-table bits where the circuit disagrees with the target.
  function automatic int ref_fit(input logic [15:0] circ, input logic [15:0] tgt, input int nbits);
    int n = 0;
    for (int i = 0; i < nbits; i++) if (circ[i] != tgt[i]) n++;
    return n;
  endfunction

  task automatic run_a(output int fit, output int perf, output int lat);
    @(posedge clk); #1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    lat = 1;
    check("a_start_clears_fit", ifa.fitness, 0);
    check("a_start_clears_perfect", ifa.perfect, 0);
    check("a_hold_while_busy", ifa.chrom_hold, 1);
    while (ifa.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ifa.done !== 1'b1) check("a_done_timeout", 0, 1);
    fit  = int'(ifa.fitness);
    perf = int'(ifa.perfect);
  endtask

  task automatic run_b(output int fit, output int perf, output int lat);
    @(posedge clk); #1;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    lat = 1;
    check("b_busy_after_start", ifb.busy, 1);
    while (ifb.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ifb.done !== 1'b1) check("b_done_timeout", 0, 1);
    fit  = int'(ifb.fitness);
    perf = int'(ifb.perfect);
  endtask

  typedef struct {
    logic [3:0] tt;
    logic [3:0] tgt;
    int         fit;
    int         perf;
  } vec_a_t;

  vec_a_t tbl[6];

  initial begin
    int fit, perf, lat, pulses, done_k, busy_cnt, exp;

    tbl[0] = '{tt: 4'b1000, tgt: 4'b0110, fit: 3, perf: 0};  // AND vs XOR
    tbl[1] = '{tt: 4'b0110, tgt: 4'b0110, fit: 0, perf: 1};  // XOR vs XOR
    tbl[2] = '{tt: 4'b0000, tgt: 4'b1111, fit: 4, perf: 0};
    tbl[3] = '{tt: 4'b1111, tgt: 4'b1110, fit: 1, perf: 0};
    tbl[4] = '{tt: 4'b0101, tgt: 4'b1010, fit: 4, perf: 0};
    tbl[5] = '{tt: 4'b1001, tgt: 4'b1001, fit: 0, perf: 1};

    rst_n      = 1'b0;
    ifa.start  = 1'b0;
    ifb.start  = 1'b0;
    ifa.target = '0;
    ifb.target = '0;
    tt_a       = '0;
    tt_b       = '0;
`ifdef FITNESS_EARLY_ABORT_EN
    ifa.abort_thr = '1;
    ifb.abort_thr = '1;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_fitness", ifa.fitness, 0);
    check("rst_perfect", ifa.perfect, 0);
    check("rst_cir_inp", ifa.cir_inp, 0);
    check("rst_hold", ifb.chrom_hold, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: AND circuit vs XOR target, vector sequence and done timing
    tt_a       = 4'b1000;
    ifa.target = 4'b0110;
    @(posedge clk); #1;
    ifa.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) ifa.start = 1'b0;
      if (k <= 4) begin
        check("t1_cir_inp_seq", ifa.cir_inp, k - 1);
        check("t1_busy", ifa.busy, 1);
        check("t1_done_early", ifa.done, 0);
      end
    end
    check("t1_done_cycle5", ifa.done, 1);
    check("t1_fitness", ifa.fitness, 3);
    check("t1_perfect", ifa.perfect, 0);
    check("t1_busy_in_done", ifa.busy, 0);
    check("t1_hold_in_done", ifa.chrom_hold, 0);
    @(posedge clk); #1;
    check("t1_done_one_cycle", ifa.done, 0);
    check("t1_fitness_held", ifa.fitness, 3);
    check("t1_cir_inp_held", ifa.cir_inp, 3);

    // Table-driven vectors (includes XOR vs XOR perfect case)
    for (int i = 0; i < 6; i++) begin
      tt_a       = tbl[i].tt;
      ifa.target = tbl[i].tgt;
      run_a(fit, perf, lat);
      check("tbl_fitness", fit, tbl[i].fit);
      check("tbl_perfect", perf, tbl[i].perf);
      check("tbl_latency", lat, 5);
    end

    // Test 4: start re-pulsed during EVAL and during DONE is ignored
    tt_a       = 4'b1000;
    ifa.target = 4'b0110;
    pulses     = 0;
    done_k     = 0;
    @(posedge clk); #1;
    ifa.start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (k == 1) ifa.start = 1'b0;
      if (k == 3) ifa.start = 1'b1;
      if (k == 4) ifa.start = 1'b0;
      if (k == 6) ifa.start = 1'b0;
      if (ifa.done === 1'b1) begin
        pulses++;
        done_k = k;
        check("t4_fitness", ifa.fitness, 3);
        ifa.start = 1'b1;
      end
    end
    ifa.start = 1'b0;
    check("t4_one_done_pulse", pulses, 1);
    check("t4_done_cycle", done_k, 5);
    check("t4_idle_at_end", ifa.busy, 0);

    // Test 3: SETTLE=2, each vector held 3 cycles, done 13 cycles after start
    tt_b       = 8'($urandom);
    ifb.target = 8'($urandom);
    exp        = ref_fit(16'(tt_b), 16'(ifb.target), 8);
    busy_cnt   = 0;
    done_k     = 0;
    @(posedge clk); #1;
    ifb.start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 1) ifb.start = 1'b0;
      if (ifb.busy === 1'b1) busy_cnt++;
      if (k <= 12) check("t3_cir_inp_hold", ifb.cir_inp, (k - 1) / 3);
      if (ifb.done === 1'b1 && done_k == 0) begin
        done_k = k;
        check("t3_fitness", ifb.fitness, exp);
        check("t3_perfect", ifb.perfect, (exp == 0) ? 1 : 0);
      end
    end
    check("t3_done_cycle", done_k, 13);
    check("t3_busy_cycles", busy_cnt, 12);

    // Test 5: asynchronous reset inside the second vector
    tt_b       = 8'b1011_0010;
    ifb.target = 8'b0110_1100;
    @(posedge clk); #1;
    ifb.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) ifb.start = 1'b0;
    end
    check("t5_in_vec1", ifb.cir_inp, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", ifb.busy, 0);
    check("t5_rst_hold", ifb.chrom_hold, 0);
    check("t5_rst_cir_inp", ifb.cir_inp, 0);
    check("t5_rst_fitness", ifb.fitness, 0);
    check("t5_rst_done", ifb.done, 0);
    check("t5_rst_perfect", ifb.perfect, 0);
    #3;
    rst_n = 1'b1;
    run_b(fit, perf, lat);
    check("t5_fitness_after_rst", fit, ref_fit(16'(tt_b), 16'(ifb.target), 8));
    check("t5_latency_after_rst", lat, 13);

`ifdef FITNESS_EARLY_ABORT_EN
    // Test 6: early abort once the running count exceeds the threshold
    tt_a          = 4'b1000;
    ifa.target    = 4'b0110;
    ifa.abort_thr = 3'd1;
    run_a(fit, perf, lat);
    check("t6_abort_latency", lat, 4);
    check("t6_abort_fitness", fit, 2);
    check("t6_abort_perfect", perf, 0);
    check("t6_aborted", ifa.aborted, 1);
    ifa.abort_thr = '1;
    run_a(fit, perf, lat);
    check("t6_no_abort_fitness", fit, 3);
    check("t6_aborted_cleared", ifa.aborted, 0);
`endif

    // Randomized sweeps against the reference model
    for (int i = 0; i < 20; i++) begin
      tt_a       = 4'($urandom);
      ifa.target = 4'($urandom);
      exp        = ref_fit(16'(tt_a), 16'(ifa.target), 4);
      run_a(fit, perf, lat);
      check("rand_a_fitness", fit, exp);
      check("rand_a_perfect", perf, (exp == 0) ? 1 : 0);
      check("rand_a_latency", lat, 5);
    end
    for (int i = 0; i < 10; i++) begin
      tt_b       = 8'($urandom);
      ifb.target = (i == 0) ? tt_b : 8'($urandom);
      exp        = ref_fit(16'(tt_b), 16'(ifb.target), 8);
      run_b(fit, perf, lat);
      check("rand_b_fitness", fit, exp);
      check("rand_b_perfect", perf, (exp == 0) ? 1 : 0);
      check("rand_b_latency", lat, 13);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
